// File: rtl/rx_buf.sv
// rx_buf: FWFT circular receive byte buffer; sticky overrun flag when RX_BUF_OVERRUN_EN is defined
module rx_buf #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            din,
  input  logic                  din_vld,
  input  logic                  rd,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovr,
  input  logic                  ovr_clr
);
  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  logic [7:0] mem_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic wr_en, rd_en;
  assign empty = count_q == '0;
  assign full  = count_q == DEPTH;
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign wr_en = din_vld && (!full || rd);
  assign rd_en = rd && !empty;
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (wr_en && !rd_en) ? count_q + 1'b1 :
               (rd_en && !wr_en) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst && wr_en) mem_q[wr_ptr_q] <= din;
`ifdef RX_BUF_OVERRUN_EN
  logic ovr_q, ovr_d;
  always_comb ovr_d = (din_vld && full && !rd) ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
  always_ff @(posedge clk) ovr_q <= rst ? 1'b0 : ovr_d;
  assign ovr = ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign ovr = 1'b0;
`endif
endmodule
